// File: rtl/dlf16_stream_accumulator.sv
// rtl/dlf16_stream_accumulator.sv - iterative DLFloat16 stream summer with output handshake
module dlf16_stream_accumulator #(
  parameter int EXP_W = 6,
  parameter int MAN_W = 9,
  parameter int BIAS  = 31,
  parameter int GRS_W = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_ovf,
  output logic        out_unf
);
  localparam int DW = 1 + EXP_W + MAN_W;
  localparam int MW = 1 + MAN_W + GRS_W;
  localparam int SW = MW + 1;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] EONE = EW'(1);
  localparam logic signed [EW-1:0] EMAX = EW'(2 * BIAS);
  localparam logic [DW-2:0] MAG_ALL1 = '1;

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE} state_t;

  state_t               state;
  logic [15:0]          acc, op;
  logic                 last, ovf, unf;
  logic                 sgn_b, sgn_s, spec, zero;
  logic signed [EW-1:0] ex;
  logic [MW-1:0]        big_m, sml_m, man;

  function automatic logic is_zero_f(input logic [15:0] v);
    return v[MAN_W +: EXP_W] == '0;
  endfunction

  function automatic logic is_spec_f(input logic [15:0] v);
    return v[DW-2:0] == MAG_ALL1;
  endfunction

  // Alignment: order by magnitude (zero counts as smallest), shift the smaller into GRS.
  logic [DW-2:0]    a_mag, b_mag;
  logic             a_big, big_zero, sml_zero, al_lost;
  logic [15:0]      big_v, sml_v;
  logic [EXP_W-1:0] ediff;
  logic [MW-1:0]    sml_full, al_m;

  always_comb begin
    a_mag    = is_zero_f(acc) ? '0 : acc[DW-2:0];
    b_mag    = is_zero_f(op) ? '0 : op[DW-2:0];
    a_big    = a_mag >= b_mag;
    big_v    = a_big ? acc : op;
    sml_v    = a_big ? op : acc;
    big_zero = is_zero_f(big_v);
    sml_zero = is_zero_f(sml_v);
    ediff    = big_v[MAN_W +: EXP_W] - sml_v[MAN_W +: EXP_W];
    sml_full = {1'b1, sml_v[MAN_W-1:0], {GRS_W{1'b0}}};
    al_lost  = 1'b0;
    for (int i = 0; i < MW; i++)
      if (i < int'(ediff)) al_lost = al_lost | sml_full[i];
    if (sml_zero)
      al_m = '0;
    else if (int'(ediff) > MAN_W + GRS_W)
      al_m = MW'(1);
    else
      al_m = (sml_full >> ediff) | MW'(al_lost);
  end

  logic [SW-1:0] sum;

  always_comb begin
    if (sgn_b == sgn_s)
      sum = {1'b0, big_m} + {1'b0, sml_m};
    else
      sum = {1'b0, big_m} - {1'b0, sml_m};
  end

  // Round-to-nearest-even; a carry out of the mantissa bumps the exponent here.
  logic                 rup, res_ovf, res_unf;
  logic [MAN_W+1:0]     rmant;
  logic signed [EW-1:0] ex_r;
  logic [MAN_W-1:0]     frac_r;
  logic [15:0]          res;

  always_comb begin
    rup     = man[GRS_W-1] & (man[GRS_W-2] | (|man[GRS_W-3:0]) | man[GRS_W]);
    rmant   = {1'b0, man[MW-1:GRS_W]} + (MAN_W+2)'(rup);
    ex_r    = rmant[MAN_W+1] ? ex + EONE : ex;
    frac_r  = rmant[MAN_W+1] ? rmant[MAN_W:1] : rmant[MAN_W-1:0];
    res_ovf = 1'b0;
    res_unf = 1'b0;
    if (spec)
      res = {1'b0, MAG_ALL1};
    else if (zero)
      res = '0;
    else if (ex < EONE || ex_r < EONE) begin
      res     = '0;
      res_unf = 1'b1;
    end else if (ex_r > EMAX) begin
      res     = {sgn_b, MAG_ALL1};
      res_ovf = 1'b1;
    end else
      res = {sgn_b, ex_r[EXP_W-1:0], frac_r};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      op        <= '0;
      last      <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
      sgn_b     <= 1'b0;
      sgn_s     <= 1'b0;
      spec      <= 1'b0;
      zero      <= 1'b0;
      ex        <= '0;
      big_m     <= '0;
      sml_m     <= '0;
      man       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            op       <= in_data;
            last     <= in_last;
            in_ready <= 1'b0;
            state    <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          spec  <= is_spec_f(acc) | is_spec_f(op);
          sgn_b <= big_v[15];
          sgn_s <= sml_v[15];
          ex    <= {2'b00, big_v[MAN_W +: EXP_W]};
          big_m <= big_zero ? '0 : {1'b1, big_v[MAN_W-1:0], {GRS_W{1'b0}}};
          sml_m <= al_m;
          state <= S_ADD;
        end
        S_ADD: begin
          man   <= sum[SW-1] ? {sum[SW-1:2], |sum[1:0]} : sum[MW-1:0];
          ex    <= sum[SW-1] ? ex + EONE : ex;
          zero  <= sum == '0;
          state <= (spec || sum == '0 || sum[SW-1] || sum[MW-1]) ? S_ROUND : S_NORM;
        end
        S_NORM: begin
          man <= man << 1;
          ex  <= ex - EONE;
          if (man[MW-2]) state <= S_ROUND;
        end
        S_ROUND: begin
          acc <= res;
          ovf <= ovf | res_ovf;
          unf <= unf | res_unf;
          if (last) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            out_data  <= res;
          end else begin
            state    <= S_IDLE;
            in_ready <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign out_ovf = ovf;
  assign out_unf = unf;
endmodule

// File: tb/tb_dlf16_stream_accumulator.sv
// tb/tb_dlf16_stream_accumulator.sv - directed bench for the DLFloat16 stream accumulator
module tb_dlf16_stream_accumulator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_ovf;
  logic        out_unf;

  int checks = 0;
  int errors = 0;

  dlf16_stream_accumulator dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_unf(out_unf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one element; lat = cycle offset (handshake cycle = 0) at which in_ready or out_valid rises.
  task automatic send(input logic [15:0] d, input logic l, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_data  = 16'($urandom_range(0, 65535));
    in_last  = 1'($urandom_range(0, 1));
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (in_ready || out_valid) begin
        lat = c + 1;
        break;
      end
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 16'($urandom_range(0, 65535));
      in_last   = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      tick();
      checks++;
      if ({out_valid, out_data, out_ovf, out_unf, in_ready} !== 20'h0) begin
        errors++;
        $display("FAIL reset_hold: valid=%b data=%h ovf=%b unf=%b ready=%b, want all 0",
                 out_valid, out_data, out_ovf, out_unf, in_ready);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_add();
    int lat;
    send(16'h3E00, 1'b0, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL add_lat1: got %0d want 4", lat);
    end
    send(16'h4000, 1'b1, lat);
    checks++;
    if (lat !== 4 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL add_lat2: lat %0d valid %b want 4 1", lat, out_valid);
    end
    checks++;
    if ({out_data, out_ovf, out_unf, in_ready} !== {16'h4100, 3'b000}) begin
      errors++;
      $display("FAIL add_result: data=%h ovf=%b unf=%b ready=%b want 4100 0 0 0",
               out_data, out_ovf, out_unf, in_ready);
    end
    take();
  endtask

  task automatic test_cancel();
    int lat;
    send(16'h4280, 1'b0, lat);
    send(16'hC280, 1'b1, lat);
    checks++;
    if (out_data !== 16'h0000 || lat !== 4 || out_unf !== 1'b0) begin
      errors++;
      $display("FAIL cancel: data=%h lat=%0d unf=%b want 0000 4 0", out_data, lat, out_unf);
    end
    take();
  endtask

  task automatic test_norm();
    int lat;
    send(16'h4100, 1'b0, lat);
    send(16'hC000, 1'b1, lat);
    checks++;
    if (out_data !== 16'h3E00 || lat !== 5) begin
      errors++;
      $display("FAIL norm: data=%h lat=%0d want 3E00 5", out_data, lat);
    end
    take();
  endtask

  task automatic test_negative();
    int lat;
    send(16'h3E00, 1'b0, lat);
    send(16'hC100, 1'b1, lat);
    checks++;
    if (out_data !== 16'hC000 || lat !== 4) begin
      errors++;
      $display("FAIL negative: data=%h lat=%0d want C000 4", out_data, lat);
    end
    take();
    send(16'h8000, 1'b1, lat);
    checks++;
    if (out_data !== 16'h0000 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL neg_zero: data=%h valid=%b want 0000 1", out_data, out_valid);
    end
    take();
  endtask

  task automatic test_round_tie();
    int lat;
    send(16'h3E00, 1'b0, lat);
    send(16'h2A00, 1'b1, lat);
    checks++;
    if ({out_data, out_ovf, out_unf} !== {16'h3E00, 2'b00}) begin
      errors++;
      $display("FAIL round_tie: data=%h ovf=%b unf=%b want 3E00 0 0", out_data, out_ovf, out_unf);
    end
    take();
  endtask

  task automatic test_overflow_special();
    int lat;
    send(16'h7FFE, 1'b0, lat);
    send(16'h7FFE, 1'b1, lat);
    checks++;
    if (out_data !== 16'h7FFF || out_ovf !== 1'b1) begin
      errors++;
      $display("FAIL overflow: data=%h ovf=%b want 7FFF 1", out_data, out_ovf);
    end
    take();
    send(16'h7FFF, 1'b0, lat);
    send(16'h3E00, 1'b1, lat);
    checks++;
    if (out_data !== 16'h7FFF || out_ovf !== 1'b0) begin
      errors++;
      $display("FAIL special: data=%h ovf=%b want 7FFF 0", out_data, out_ovf);
    end
    take();
  endtask

  task automatic test_backpressure();
    int lat;
    send(16'h7FFE, 1'b1, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h3E00;
      tick();
      checks++;
      if ({out_valid, out_data, out_ovf, in_ready} !== {1'b1, 16'h7FFF, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold: valid=%b data=%h ovf=%b ready=%b want 1 7FFF 1 0",
                 out_valid, out_data, out_ovf, in_ready);
      end
    end
    in_valid = 1'b0;
    take();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: valid=%b ready=%b want 0 1", out_valid, in_ready);
    end
    send(16'h4000, 1'b1, lat);
    checks++;
    if ({out_data, out_ovf, out_unf} !== {16'h4000, 2'b00}) begin
      errors++;
      $display("FAIL bp_next: data=%h ovf=%b unf=%b want 4000 0 0", out_data, out_ovf, out_unf);
    end
    take();
  endtask

  task automatic test_reset_in_norm();
    int lat;
    send(16'h4100, 1'b0, lat);
    in_valid = 1'b1;
    in_data  = 16'hC000;
    in_last  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, out_data} !== 18'h0) begin
      errors++;
      $display("FAIL norm_reset: valid=%b ready=%b data=%h want 0 0 0000", out_valid, in_ready, out_data);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL norm_reset_idle: ready=%b valid=%b want 1 0", in_ready, out_valid);
    end
    send(16'h3E00, 1'b1, lat);
    checks++;
    if (out_data !== 16'h3E00 || lat !== 4) begin
      errors++;
      $display("FAIL norm_reset_sum: data=%h lat=%0d want 3E00 4", out_data, lat);
    end
    take();
  endtask

  initial begin
    test_reset();
    test_add();
    test_cancel();
    test_norm();
    test_negative();
    test_round_tie();
    test_overflow_special();
    test_backpressure();
    test_reset_in_norm();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
